// File: rtl/serial_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_add_sub: digit-serial add/subtract, LSB digit first, start/done.    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]       a_sh, b_sh, acc;
  logic                   carry;
  logic [CW-1:0]          cnt;
  logic                   accept, last;
  logic [DIGIT-1:0]       a_dig, b_dig, sum_dig;
  logic                   c_dig, c_msb;
  logic [WIDTH+DIGIT-1:0] acc_cat;

  // One DIGIT-wide ripple slice; carry into the slice MSB is recovered from its sum bit.
  always_comb begin
    a_dig            = a_sh[DIGIT-1:0];
    b_dig            = b_sh[DIGIT-1:0];
    {c_dig, sum_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    c_msb            = sum_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    acc_cat          = {sum_dig, acc};
    last             = (cnt == CW'(N - 1));
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // Subtraction folds into addition: a + ~b + ~cin.
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      acc   <= acc_cat[WIDTH+DIGIT-1:DIGIT];
      carry <= c_dig;
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        s    <= acc_cat[WIDTH+DIGIT-1:DIGIT];
        cout <= c_dig;
        ovf  <= c_dig ^ c_msb;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_add_sub: scoreboard bench over five digit/width configurations.  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_serial_add_sub;

  logic        clk;
  logic        rst_n;
  logic [4:0]  start_v;
  logic [15:0] a, b;
  logic        cin, sub;
  logic [4:0]  busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  s8 [4];
  logic [15:0] s16;
  logic [17:0] obs [5];

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] exp_q [5][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instances 0..3: WIDTH=8 with DIGIT=1,2,4,8; instance 4: WIDTH=16, DIGIT=8.
  for (genvar g = 0; g < 4; g++) begin : g_dut8
    serial_add_sub #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .a(a[7:0]), .b(b[7:0]),
      .cin(cin), .sub(sub), .busy(busy_v[g]), .done(done_v[g]), .s(s8[g]),
      .cout(cout_v[g]), .ovf(ovf_v[g])
    );
  end

  serial_add_sub #(.WIDTH(16), .DIGIT(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy_v[4]), .done(done_v[4]), .s(s16),
    .cout(cout_v[4]), .ovf(ovf_v[4])
  );

  always_comb begin
    for (int k = 0; k < 4; k++) obs[k] = {cout_v[k], ovf_v[k], 8'h00, s8[k]};
    obs[4] = {cout_v[4], ovf_v[4], s16};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int wd(input int k);
    return (k == 4) ? 16 : 8;
  endfunction

  function automatic int nd(input int k);
    return (k == 4) ? 2 : (8 >> k);
  endfunction

  // Reference: exact integer arithmetic, {cout, ovf, s} zero-extended to 16 bits.
  function automatic logic [17:0] ref_calc(input int w, input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic sb);
    int msk, ua, ub, sa, sy, u, sres, lim;
    logic co, ov;
    msk = (1 << w) - 1;
    ua  = int'(x) & msk;
    ub  = int'(y) & msk;
    lim = 1 << (w - 1);
    sa  = (ua >= lim) ? ua - (1 << w) : ua;
    sy  = (ub >= lim) ? ub - (1 << w) : ub;
    if (!sb) begin
      u    = ua + ub + int'(ci);
      sres = sa + sy + int'(ci);
      co   = (u > msk);
    end else begin
      u    = ua - ub - int'(ci);
      sres = sa - sy - int'(ci);
      co   = (u >= 0);
    end
    ov = (sres > lim - 1) || (sres < -lim);
    return {co, ov, 16'(u & msk)};
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (done_v[k] === 1'b1) begin
        check($sformatf("busy_with_done%0d", k), busy_v[k], 0);
        if (exp_q[k].size() == 0) check($sformatf("spurious_done%0d", k), 1, 0);
        else check($sformatf("result%0d", k), obs[k], exp_q[k].pop_front());
      end
    end
  end

  task automatic do_op(input logic [4:0] m, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, input logic ts);
    int done_at [5];
    int busy_n  [5];
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; start_v = m;
    for (int k = 0; k < 5; k++) begin
      done_at[k] = 0;
      busy_n[k]  = 0;
      if (m[k]) exp_q[k].push_back(ref_calc(wd(k), ta, tb, tc, ts));
    end
    @(posedge clk);
    #1;
    start_v = '0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        if (busy_v[k] === 1'b1) busy_n[k]++;
        if (done_v[k] === 1'b1 && done_at[k] == 0) done_at[k] = c;
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (m[k]) begin
        check($sformatf("latency%0d", k), done_at[k], nd(k) + 1);
        check($sformatf("busy_cycles%0d", k), busy_n[k], nd(k));
      end
    end
  endtask

  typedef struct packed {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vc;
    logic        vs;
  } vec_t;

  vec_t vecs [9];
  logic [17:0] exp1;
  int          lat;

  initial begin
    vecs[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b0};
    vecs[2] = '{16'h007F, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h00FF, 16'h00FF, 1'b1, 1'b0};
    vecs[4] = '{16'h0005, 16'h0003, 1'b0, 1'b1};
    vecs[5] = '{16'h0000, 16'h0001, 1'b0, 1'b1};
    vecs[6] = '{16'h0080, 16'h0001, 1'b0, 1'b1};
    vecs[7] = '{16'h0003, 16'h0003, 1'b1, 1'b1};
    vecs[8] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0};

    rst_n = 1'b0; start_v = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("reset_out%0d", k), obs[k], 0);
      check($sformatf("reset_flags%0d", k), {busy_v[k], done_v[k]}, 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_op(5'b11111, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vs);

    // Start pulsed mid-RUN with other operands must be ignored.
    @(negedge clk);
    a = 16'h0012; b = 16'h0034; cin = 1'b0; sub = 1'b0; start_v = 5'b00001;
    exp_q[0].push_back(ref_calc(8, 16'h0012, 16'h0034, 1'b0, 1'b0));
    @(posedge clk); #1 start_v = '0;
    repeat (3) @(negedge clk);
    a = 16'h00AA; b = 16'h0055; sub = 1'b1; start_v = 5'b00001;
    @(negedge clk) start_v = '0;
    repeat (14) @(negedge clk);

    // Start held high through DONE: second operation accepted in the done cycle.
    @(negedge clk);
    a = 16'h0021; b = 16'h0043; cin = 1'b1; sub = 1'b0; start_v = 5'b00001;
    exp1 = ref_calc(8, 16'h0021, 16'h0043, 1'b1, 1'b0);
    exp_q[0].push_back(exp1);
    exp_q[0].push_back(ref_calc(8, 16'h0080, 16'h0001, 1'b0, 1'b1));
    @(posedge clk); #1;
    a = 16'h0080; b = 16'h0001; cin = 1'b0; sub = 1'b1;
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) lat = c;
    end
    check("held_lat1", lat, 9);
    @(posedge clk); #1;
    start_v = '0; a = 16'h00FF; b = 16'h00FF;
    repeat (4) @(negedge clk);
    check("hold_old_result", obs[0], exp1);
    check("second_running", busy_v[0], 1);
    lat = 4;
    while (lat < 14 && done_v[0] !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    check("held_lat2", lat, 9);
    repeat (3) @(negedge clk);

    // Reset during RUN aborts the operation with no done pulse.
    a = 16'h0055; b = 16'h0022; cin = 1'b0; sub = 1'b0; start_v = 5'b00001;
    @(posedge clk); #1 start_v = '0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", busy_v[0], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_out", obs[0], 0);
    check("abort_flags", {busy_v[0], done_v[0]}, 0);
    repeat (12) @(negedge clk);
    do_op(5'b00001, 16'h0040, 16'h0041, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++)
      do_op(5'b11111, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) check($sformatf("queue_empty%0d", k), exp_q[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
